// File: rtl/life_hud.sv
// life_hud: heart/life HUD for the game overlay.
// Owns the player life counter, applies per-frame hit/heal/revive events,
// runs a post-hit invulnerability window, and produces per-slot sprite-on
// flags plus the sprite-ROM pixel offset of the lowest-index lit slot.
// Optional feature macro: LIFE_HUD_BLINK_EN (hearts blink during the
// invulnerability window). Without it hearts stay steady while invulnerable.
// Handshake note: there is no valid/ready pair; events are level-sampled on
// every frame_clk rising edge and state outputs are valid for the whole
// following frame, while pixel outputs are combinational from DrawX/DrawY.
module life_hud #(
  parameter int MAX_LIFE      = 5,
  parameter int START_LIFE    = 3,
  parameter int SPRITE_SHIFT  = 4,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_PERIOD  = 8
) (
  input  logic                      frame_clk,
  input  logic                      RESET,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic                      hit,
  input  logic                      heal,
  input  logic                      revive,
  input  logic [10*MAX_LIFE-1:0]    heart_row,
  input  logic [10*MAX_LIFE-1:0]    heart_col,
  output logic [3:0]                life,
  output logic                      dead,
  output logic                      invuln,
  output logic [MAX_LIFE-1:0]       hearton,
  output logic                      any_on,
  output logic [SPRITE_SHIFT-1:0]   rom_x,
  output logic [SPRITE_SHIFT-1:0]   rom_y
);

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_INVULN = 2'd1,
    ST_DEAD   = 2'd2
  } state_e;

  localparam logic [3:0]  MAX_L   = 4'(MAX_LIFE);
  localparam logic [3:0]  START_L = 4'(START_LIFE);
  localparam logic [9:0]  INV_F   = 10'(INVULN_FRAMES);
  localparam logic [10:0] SPR_W   = 11'(2 ** SPRITE_SHIFT);

  state_e     state_q, state_d;
  logic [3:0] life_q, life_d;
  logic [9:0] timer_q, timer_d;
  logic [3:0] life_inc;
  logic       visible;

  // Heal result, saturating at the ceiling.
  assign life_inc = (life_q < MAX_L) ? life_q + 4'd1 : life_q;

  // Next-state logic for the life FSM, life counter and invulnerability timer.
  always_comb begin
    state_d = state_q;
    life_d  = life_q;
    timer_d = timer_q;
    case (state_q)
      ST_ALIVE: begin
        if (hit && !heal) begin
          if (life_q > 4'd1) begin
            life_d  = life_q - 4'd1;
            timer_d = INV_F;
            state_d = ST_INVULN;
          end else begin
            life_d  = 4'd0;
            state_d = ST_DEAD;
          end
        end else if (heal && !hit) begin
          life_d = life_inc;
        end
      end
      ST_INVULN: begin
        // hit is ignored here, so a coincident heal still applies
        if (heal) life_d = life_inc;
        timer_d = timer_q - 10'd1;
        if (timer_q == 10'd1) state_d = ST_ALIVE;
      end
      ST_DEAD: begin
        if (revive) begin
          life_d  = START_L;
          state_d = ST_ALIVE;
        end
      end
      default: state_d = ST_ALIVE;
    endcase
  end

  // State registers; reset overrides every event.
  always_ff @(posedge frame_clk) begin
    if (RESET) begin
      state_q <= ST_ALIVE;
      life_q  <= START_L;
      timer_q <= 10'd0;
    end else begin
      state_q <= state_d;
      life_q  <= life_d;
      timer_q <= timer_d;
    end
  end

`ifdef LIFE_HUD_BLINK_EN
  localparam logic [7:0] BP_LAST = 8'(BLINK_PERIOD - 1);

  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       hidden_q, hidden_d;

  // Blink counter: cleared on INVULN entry, toggles phase every BLINK_PERIOD frames.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    hidden_d    = hidden_q;
    if (state_q == ST_ALIVE && state_d == ST_INVULN) begin
      blink_cnt_d = 8'd0;
      hidden_d    = 1'b0;
    end else if (state_q == ST_INVULN) begin
      if (blink_cnt_q == BP_LAST) begin
        blink_cnt_d = 8'd0;
        hidden_d    = ~hidden_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  // Blink registers; phase starts visible.
  always_ff @(posedge frame_clk) begin
    if (RESET) begin
      blink_cnt_q <= 8'd0;
      hidden_q    <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      hidden_q    <= hidden_d;
    end
  end

  assign visible = (state_q != ST_INVULN) || !hidden_q;
`else
  assign visible = 1'b1;
`endif

  logic [SPRITE_SHIFT-1:0] off_x [MAX_LIFE];
  logic [SPRITE_SHIFT-1:0] off_y [MAX_LIFE];

  // Per-slot sprite window test; sums are 11 bits so edge sprites do not wrap.
  for (genvar g = 0; g < MAX_LIFE; g++) begin : g_slot
    logic [9:0] x0, y0;
    logic       in_x, in_y;
    assign x0   = heart_col[g*10 +: 10] << SPRITE_SHIFT;
    assign y0   = heart_row[g*10 +: 10] << SPRITE_SHIFT;
    assign in_x = ({1'b0, DrawX} >= {1'b0, x0}) && ({1'b0, DrawX} < ({1'b0, x0} + SPR_W));
    assign in_y = ({1'b0, DrawY} >= {1'b0, y0}) && ({1'b0, DrawY} < ({1'b0, y0} + SPR_W));
    assign hearton[g] = (4'(g) < life_q) && in_x && in_y && visible;
    assign off_x[g] = DrawX[SPRITE_SHIFT-1:0] - x0[SPRITE_SHIFT-1:0];
    assign off_y[g] = DrawY[SPRITE_SHIFT-1:0] - y0[SPRITE_SHIFT-1:0];
  end

  // ROM offset of the lowest-index lit slot; scanning downward lets low indices win.
  always_comb begin
    rom_x = '0;
    rom_y = '0;
    for (int i = MAX_LIFE - 1; i >= 0; i--) begin
      if (hearton[i]) begin
        rom_x = off_x[i];
        rom_y = off_y[i];
      end
    end
  end

  assign any_on = |hearton;
  assign life   = life_q;
  assign dead   = (state_q == ST_DEAD);
  assign invuln = (state_q == ST_INVULN);

endmodule

// File: doc/life_hud.md
# life_hud

Parametrised heart/life HUD for the game overlay. Owns the player life counter, processes per-frame hit/heal/revive events, and runs an invulnerability window with blinking hearts after each hit. It also generates per-slot sprite-on flags and a sprite-ROM pixel offset for the colour mapper. It replaces the fixed three-heart display and sits between game logic (event sources) and the colour mapper (pixel consumer).

## Interface
Parameters:
- MAX_LIFE, 5: number of heart slots and the life ceiling (1..15).
- START_LIFE, 3: life after reset or revive (1..MAX_LIFE).
- SPRITE_SHIFT, 4: log2 of sprite edge in pixels; slot grid cell = 16 px.
- INVULN_FRAMES, 60: length of the post-hit invulnerability window in frames (1..1023).
- BLINK_PERIOD, 8: frames per blink phase (1..255).

Ports:
- frame_clk  in  1  one rising edge per video frame; only clock.
- RESET  in  1  synchronous, active-high.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- hit  in  1  damage event, sampled on frame_clk.
- heal  in  1  +1 life event, sampled on frame_clk.
- revive  in  1  restart event, honoured only in DEAD.
- heart_row  in  10 x MAX_LIFE  grid row of each slot.
- heart_col  in  10 x MAX_LIFE  grid column of each slot.
- life  out  4  current life count.
- dead  out  1  high in DEAD.
- invuln  out  1  high in INVULN.
- hearton  out  MAX_LIFE  per-slot pixel-on flag.
- any_on  out  1  OR of hearton.
- rom_x  out  SPRITE_SHIFT  pixel column offset inside the lowest-index active sprite.
- rom_y  out  SPRITE_SHIFT  pixel row offset inside the lowest-index active sprite.

## Operation
- Registered state: FSM state, life, invuln timer (10 b), blink counter (8 b), blink phase.
- ALIVE:
  - hit with life>1: life−1, timer←INVULN_FRAMES, phase←visible, go INVULN.
  - hit with life==1: life←0, go DEAD.
  - heal: life+1, saturating at MAX_LIFE.
  - hit and heal together: cancel; life unchanged, no state change.
- INVULN:
  - hit is ignored.
  - heal behaves as in ALIVE.
  - timer decrements each frame; the edge on which timer==1 returns to ALIVE.
- DEAD:
  - hit and heal are ignored.
  - revive: life←START_LIFE, go ALIVE.
- revive outside DEAD is ignored.
- Slot i is displayed iff i < life. Pixel geometry:
  - X0 = heart_col[i]<<SPRITE_SHIFT, Y0 = heart_row[i]<<SPRITE_SHIFT, truncated to 10 b.
  - hearton[i] = displayed & X0≤DrawX<X0+2^SPRITE_SHIFT & Y0≤DrawY<Y0+2^SPRITE_SHIFT & visible.
  - Compares use 11-bit sums, so sprites at the right/bottom edge do not wrap.
- visible = 1 outside INVULN; inside INVULN it follows blink phase.
- rom_x/rom_y = DrawX−X0 and DrawY−Y0 (low SPRITE_SHIFT bits) for the lowest active i; 0 when any_on=0.

## Timing
- All state updates on the rising edge of frame_clk. hearton, any_on, rom_x and rom_y are combinational from DrawX/DrawY and registered state, with no added pixel latency.
- RESET, highest priority over all events: life=START_LIFE, state ALIVE, timer=0, blink counter=0, phase visible, dead=0, invuln=0.
- Asserting RESET mid-INVULN or in DEAD fully restores the reset state on that edge.
- Event-to-output latency: life/dead/invuln change on the same edge that samples the event and are visible in the following frame.
- invuln is high for exactly INVULN_FRAMES frames after the sampling edge.
- Blink counter is cleared on INVULN entry and increments each INVULN frame. Phase toggles when the counter reaches BLINK_PERIOD−1; the counter then wraps to 0.
- Phase is visible for the first BLINK_PERIOD frames of INVULN.

## Configuration
- LIFE_HUD_BLINK_EN defined: blinking as specified.
- LIFE_HUD_BLINK_EN undefined:
  - blink counter and phase are not built;
  - visible is constantly 1, so hearts stay steady during INVULN;
  - invuln timing and the hit-ignore rule are unchanged.

## Test plan
- Reset with MAX_LIFE=5, START_LIFE=3 → life=3, dead=0, invuln=0. DrawX/DrawY inside slot 2 at (row 1, col 4), i.e. pixel (70,20) → hearton[2]=1, rom_x=6, rom_y=4; slot 3 → 0.
- Single hit pulse → life=2, invuln high for exactly 60 frames. A second hit at frame 10 is ignored, life stays 2. Then ALIVE.
- Blink, INVULN_FRAMES=60, BLINK_PERIOD=8:
  - slot 0 visible on frames 0–7, hidden 8–15, visible 16–23;
  - with LIFE_HUD_BLINK_EN undefined, visible on all 60 frames.
- Heal ×4 from life 3 → life saturates at 5. Simultaneous hit+heal at life 5 → life 5, no INVULN.
- From life 1, hit → life=0, dead=1, all hearton=0. Heal ignored. Revive → life=3, ALIVE.
- RESET asserted at INVULN frame 20 → next frame life=3, invuln=0, timer=0.
